// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with sticky halt, stall hold, branch redirect
// and a circular return-address stack for call/ret.
module pc_unit_ras #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP      = 2,
    parameter logic [15:0] RESET_VEC = 16'h0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_seq,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic             hold;
    logic [PTR_W-1:0] top_idx;

    assign pc_seq  = pc_q + WIDTH'(STEP);
    assign top_idx = ptr_q - PTR_W'(1);

    // Next-state: hold freezes everything; otherwise ret > redirect > sequential
    always_comb begin
        hold     = halt_req | (halted_q & ~resume) | stall;
        halted_d = halt_req | (halted_q & ~resume);
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        ras_d    = ras_q;
        if (!hold) begin
            if (ret) begin
                if (cnt_q == CNT_W'(0)) begin
                    pc_d  = pc_seq;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_idx];
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (redirect_valid) begin
                pc_d = redirect_addr;
                if (call) begin
                    ras_d[ptr_q] = pc_seq;
                    ptr_d        = ptr_q + PTR_W'(1);
                    // Full stack: pointer wrap overwrites the oldest entry
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= WIDTH'(RESET_VEC);
            halted_q <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Stack contents carry no reset; validity is tracked by cnt_q
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign pc_out    = pc_q;
    assign halted    = halted_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
    assign ras_empty = (cnt_q == CNT_W'(0));
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

endmodule
